// File: rtl/csa_accumulator_pkg.sv
// Shared types, default widths and operand alignment for the carry-save accumulator.
package csa_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int unsigned DEF_IN_W    = 17;
  localparam int unsigned DEF_ACC_W   = 34;
  localparam int unsigned DEF_SHIFT   = 2;
  localparam int unsigned DEF_MAX_OPS = 9;
  localparam int unsigned ALIGN_W     = 64;

  // Sign-extends an in_w-bit row held in the low bits, then shifts; huge shifts give zero.
  function automatic logic [ALIGN_W-1:0] sext_shift(input logic [ALIGN_W-1:0] row,
                                                     input int unsigned       in_w,
                                                     input int unsigned       shamt);
    logic [ALIGN_W-1:0] mask;
    logic [ALIGN_W-1:0] ext;
    mask = (ALIGN_W'(1) << in_w) - ALIGN_W'(1);
    ext  = row[in_w-1] ? (row | ~mask) : (row & mask);
    if (shamt >= ALIGN_W) return '0;
    return ext << shamt;
  endfunction

endpackage

// File: rtl/csa_accumulator_csa_3to2.sv
// Width-parametrised 3:2 compressor row: W independent full-adder cells.
module csa_3to2 #(
  parameter int unsigned W = 34
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_s,
  output logic [W-1:0] o_c,
  output logic [W-1:0] o_c_shl
);

  logic [W-1:0] w_s;
  logic [W-1:0] w_c;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign w_s[g] = i_a[g] ^ i_b[g] ^ i_c[g];
    assign w_c[g] = (i_a[g] & i_b[g]) | (i_a[g] & i_c[g]) | (i_b[g] & i_c[g]);
  end

  assign o_s     = w_s;
  assign o_c     = w_c;
  // Carry moves up one weight; the MSB carry falls off (modulo 2^W arithmetic).
  assign o_c_shl = {w_c[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Sequential carry-save accumulator: one 3:2 row per accepted input, one final CPA.
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int unsigned IN_W    = DEF_IN_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned SHIFT   = DEF_SHIFT,
  parameter int unsigned MAX_OPS = DEF_MAX_OPS,
  localparam int unsigned CNT_W  = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_forced
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_vs;
  logic [ACC_W-1:0] r_vc;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_forced;

  logic [ALIGN_W-1:0] w_align;
  logic [ACC_W-1:0]   w_z;
  logic [ACC_W-1:0]   w_s;
  logic [ACC_W-1:0]   w_c;
  logic [ACC_W-1:0]   w_c_shl;
  logic               w_accept;
  logic               w_last_idx;

  assign w_align    = sext_shift(ALIGN_W'(in_data), IN_W, SHIFT * (32'(r_count)));
  assign w_z        = w_align[ACC_W-1:0];
  assign w_accept   = (r_state == ACCUM) && in_valid;
  assign w_last_idx = (r_count == CNT_W'(MAX_OPS - 1));

  csa_3to2 #(.W(ACC_W)) u_csa (
    .i_a     (r_vs),
    .i_b     (r_vc),
    .i_c     (w_z),
    .o_s     (w_s),
    .o_c     (w_c),
    .o_c_shl (w_c_shl)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && (in_last || w_last_idx)) w_state_nxt = RESOLVE;
      RESOLVE: w_state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs         <= '0;
      r_vc         <= '0;
      r_count      <= '0;
      r_out_sum    <= '0;
      r_out_count  <= '0;
      r_out_forced <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_vs    <= w_s;
            r_vc    <= w_c_shl;
            r_count <= r_count + CNT_W'(1);
            if (in_last || w_last_idx) r_out_forced <= !in_last && w_last_idx;
          end
        end
        RESOLVE: begin
          r_out_sum   <= r_vs + r_vc;
          r_out_count <= r_count;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_vs    <= '0;
            r_vc    <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ACCUM);
  assign out_valid  = (r_state == OUTPUT);
  assign out_sum    = r_out_sum;
  assign out_count  = r_out_count;
  assign out_forced = r_out_forced;

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: directed groups plus random groups with gaps.
module tb_csa_accumulator;

  localparam int unsigned IN_W    = 17;
  localparam int unsigned ACC_W   = 34;
  localparam int unsigned SHIFT   = 2;
  localparam int unsigned MAX_OPS = 9;
  localparam int unsigned CNT_W   = $clog2(MAX_OPS + 1);

  typedef struct {
    logic [ACC_W-1:0] sum;
    int               cnt;
    bit               forced;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_forced;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     rdy_mode = 0;
  exp_t   sb[$];
  longint rows[$];

  csa_accumulator #(
    .IN_W    (IN_W),
    .ACC_W   (ACC_W),
    .SHIFT   (SHIFT),
    .MAX_OPS (MAX_OPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_forced (out_forced)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Reference: sum of row_k * 4^k, taken modulo 2^ACC_W.
  function automatic exp_t model(input bit forced);
    exp_t   e;
    longint acc;
    acc = 0;
    for (int k = 0; k < rows.size(); k++)
      acc = acc + rows[k] * (longint'(1) << (SHIFT * k));
    e.sum    = ACC_W'(acc);
    e.cnt    = rows.size();
    e.forced = forced;
    return e;
  endfunction

  task automatic send_row(input logic [IN_W-1:0] d, input bit last);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      bound_fail("in_ready_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    rows.push_back(longint'($signed(d)));
    if (last || rows.size() == MAX_OPS) begin
      sb.push_back(model(!last));
      rows.delete();
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (sb.size() != 0) bound_fail("drain");
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: a result is consumed on the edge after a negedge that sees valid & ready.
  always begin
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        bound_fail("unexpected_output");
      end else begin
        e = sb.pop_front();
        check("out_sum", 64'(out_sum), 64'(e.sum));
        check("out_count", 64'(out_count), 64'(e.cnt));
        check("out_forced", 64'(out_forced), 64'(e.forced));
      end
    end
  end

  initial begin
    logic [IN_W-1:0] d;
    int n;
    int waited;
    bit use_last;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_forced", 64'(out_forced), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single row with latency check
    send_row(17'd5, 1'b1);
    check("lat_resolve_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_output_valid", 64'(out_valid), 64'd1);
    wait_drain();

    // Weighted rows and signed rows
    send_row(17'd1, 1'b0);
    send_row(17'd1, 1'b0);
    send_row(17'd1, 1'b1);
    send_row(17'h1FFFF, 1'b0);
    send_row(17'd3, 1'b1);
    send_row(17'h1FFFE, 1'b0);
    send_row(17'h1FFFE, 1'b1);
    wait_drain();

    // Output stall holds the result and blocks input
    rdy_mode  = 2;
    out_ready = 1'b0;
    send_row(17'd9, 1'b1);
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) bound_fail("stall_valid_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_sum", 64'(out_sum), 64'd9);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rdy_mode  = 0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready_same", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("release_in_ready_next", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    send_row(17'd2, 1'b0);
    send_row(17'd2, 1'b1);
    wait_drain();

    // MAX_OPS forces the group end; the tenth row opens a new group
    for (int i = 0; i < 9; i++) send_row(17'd1, 1'b0);
    send_row(17'd1, 1'b0);
    send_row(17'd5, 1'b1);
    wait_drain();

    // Reset mid-group discards the partial group
    send_row(17'd3, 1'b0);
    send_row(17'd3, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    check("midrst_out_count", 64'(out_count), 64'd0);
    check("midrst_out_forced", 64'(out_forced), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rows.delete();
    send_row(17'd7, 1'b1);
    wait_drain();

    // Random groups with input gaps and output backpressure
    rdy_mode = 1;
    for (int g = 0; g < 40; g++) begin
      n        = $urandom_range(1, MAX_OPS);
      use_last = (n < MAX_OPS) || ($urandom_range(0, 1) == 1);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0:       d = 17'h10000;
          1:       d = 17'h0FFFF;
          2:       d = 17'h1FFFF;
          default: d = IN_W'($urandom);
        endcase
        send_row(d, use_last && (k == n - 1));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
